// File: rtl/act_requant_packer.sv
// act_requant_packer: latches one activated vector, requantizes each element
// to OUT_WIDTH with round-half-up shift and saturation, streams LANES per beat.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   vector handshake; in_data + shift sampled on accept
//   out_valid/out_ready beat handshake toward writeback
//   out_data            LANES requantized elements of the current beat
//   out_last, out_beat  beat position within the vector
//   out_sat             some lane of the current beat saturated
//   stats_clear         zeroes sat_total (wins over increment)
//   sat_total           sticky-saturating count of saturated lanes accepted

module act_requant_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int VECTOR_WIDTH = 32,
  parameter int OUT_WIDTH    = 8,
  parameter int LANES        = 4,
  parameter int SHIFT_W      = 5,
  localparam int BEATS  = VECTOR_WIDTH / LANES,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic [SHIFT_W-1:0]            shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_WIDTH-1:0]    out_data,
  output logic                          out_last,
  output logic [BEAT_W-1:0]             out_beat,
  output logic                          out_sat,
  input  logic                          stats_clear,
  output logic [15:0]                   sat_total
);

  localparam int DW    = DATA_WIDTH;
  localparam int OW    = OUT_WIDTH;
  localparam int CNT_W = $clog2(LANES + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Saturation bounds in the widened (DW+1) domain.
  localparam logic signed [DW:0] MAXV = (DW+1)'(2**(OW-1) - 1);
  localparam logic signed [DW:0] MINV = ~MAXV;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t              state;
  logic [DW-1:0]       vbuf [BEATS][LANES];
  logic [SHIFT_W-1:0]  shift_q;
  logic [BEAT_W-1:0]   beat;

  logic                in_fire;
  logic                out_fire;
  logic [LANES-1:0]    lane_sat;
  logic [CNT_W-1:0]    sat_cnt;
  logic [16:0]         sat_sum;

  assign out_beat = beat;
  assign out_last = out_valid && (beat == LAST_BEAT);
  assign out_fire = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (out_fire && out_last);
  assign in_fire  = in_valid && in_ready;
  assign out_sat  = |lane_sat;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DW:0] xe;
    logic        [DW:0] rnd;
    logic signed [DW:0] sum;
    logic signed [DW:0] r;
    logic               hi;
    logic               lo;

    assign xe  = $signed({vbuf[beat][l][DW-1], vbuf[beat][l]});
    // 2^(s-1) for s>0, zero for s==0
    assign rnd = ((DW+1)'(1) << shift_q) >> 1;
    assign sum = xe + $signed(rnd);
    assign r   = sum >>> shift_q;
    assign hi  = r > MAXV;
    assign lo  = r < MINV;

    assign lane_sat[l] = hi | lo;
    assign out_data[l*OW +: OW] = hi ? MAXV[OW-1:0] :
                                  lo ? MINV[OW-1:0] :
                                       r[OW-1:0];
  end

  always_comb begin
    sat_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      sat_cnt = sat_cnt + CNT_W'(lane_sat[l]);
    end
  end

  assign sat_sum = {1'b0, sat_total} + 17'(sat_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      beat      <= '0;
      shift_q   <= '0;
      sat_total <= '0;
      for (int b = 0; b < BEATS; b++) begin
        for (int l = 0; l < LANES; l++) begin
          vbuf[b][l] <= '0;
        end
      end
    end else begin
      if (in_fire) begin
        for (int b = 0; b < BEATS; b++) begin
          for (int l = 0; l < LANES; l++) begin
            vbuf[b][l] <= in_data[(b*LANES+l)*DW +: DW];
          end
        end
        shift_q   <= shift;
        beat      <= '0;
        state     <= STREAM;
        out_valid <= 1'b1;
      end else if (out_fire && out_last) begin
        beat      <= '0;
        state     <= IDLE;
        out_valid <= 1'b0;
      end else if (out_fire) begin
        beat <= beat + BEAT_W'(1);
      end

      if (stats_clear) begin
        sat_total <= '0;
      end else if (out_fire) begin
        sat_total <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_act_requant_packer.sv
// tb_act_requant_packer: directed vectors with a beat scoreboard
// and a monitor that pops on every accepted output beat.

module tb_act_requant_packer;

  localparam int DW = 32;
  localparam int VW = 32;
  localparam int OW = 8;
  localparam int LN = 4;
  localparam int SW = 5;
  localparam int NB = VW / LN;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [VW*DW-1:0]  in_data;
  logic [SW-1:0]     shift;
  logic              out_valid;
  logic              out_ready;
  logic [LN*OW-1:0]  out_data;
  logic              out_last;
  logic [2:0]        out_beat;
  logic              out_sat;
  logic              stats_clear;
  logic [15:0]       sat_total;

  always #5 clk = ~clk;

  act_requant_packer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .shift       (shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_beat    (out_beat),
    .out_sat     (out_sat),
    .stats_clear (stats_clear),
    .sat_total   (sat_total)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  beat;
    logic        last;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic bp_en = 1'b0;
  int   bp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Floor division reference: round half toward +inf, then clamp.
  function automatic void requant(input longint x, input int s,
                                  output logic [7:0] r, output logic sat);
    longint d, v, q;
    d = longint'(1) << s;
    v = x + ((s > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    sat = 1'b0;
    if (q > 127) begin
      r = 8'h7F;
      sat = 1'b1;
    end else if (q < -128) begin
      r = 8'h80;
      sat = 1'b1;
    end else begin
      r = q[7:0];
    end
  endfunction

  task automatic send(input int e[VW], input int sh);
    logic       acc;
    int         n;
    exp_t       x;
    logic [7:0] r;
    logic       s;
    for (int i = 0; i < VW; i++) in_data[i*DW +: DW] = e[i];
    shift    = sh[SW-1:0];
    in_valid = 1'b1;
    for (int b = 0; b < NB; b++) begin
      x = '0;
      for (int l = 0; l < LN; l++) begin
        requant(longint'(e[b*LN+l]), sh, r, s);
        x.data[l*8 +: 8] = r;
        x.sat = x.sat | s;
      end
      x.beat = 3'(b);
      x.last = (b == NB - 1);
      sb.push_back(x);
    end
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", {62'd0, sb.size() == 0, out_valid}, 64'd2);
  endtask

  // backpressure pattern 1,0,0,1,0,0...
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic        pstall;
    logic [31:0] pdata;
    logic [2:0]  pbeat;
    exp_t        e;
    pstall = 1'b0;
    pdata  = '0;
    pbeat  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pstall && out_valid) begin
          check("stall_data", 64'(out_data), 64'(pdata));
          check("stall_beat", 64'(out_beat), 64'(pbeat));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got beat %0d expected none",
                     out_beat);
          end else begin
            e = sb.pop_front();
            check("beat", 64'({out_data, out_beat, out_last, out_sat}),
                  64'(e));
          end
        end
        pstall = out_valid && !out_ready;
        pdata  = out_data;
        pbeat  = out_beat;
      end else begin
        pstall = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[VW];
    int eb[VW];
    int n;
    int t0;
    int t1;
    int nv;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    shift       = '0;
    out_ready   = 1'b1;
    stats_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_beat", 64'(out_beat), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_sat", 64'(out_sat), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_total", 64'(sat_total), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // ramp, shift 0
    for (int i = 0; i < VW; i++) e[i] = i - 16;
    send(e, 0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_beat0", 64'(out_beat), 64'd0);
    check("t1_data0", 64'(out_data), 64'hF3F2F1F0);
    drain();
    check("t1_total", 64'(sat_total), 64'd0);

    // rounding, shift 1
    for (int i = 0; i < VW; i++) e[i] = 0;
    e[0] = 5;
    e[1] = -5;
    e[2] = 3;
    e[3] = -3;
    send(e, 1);
    check("t2_data0", 64'(out_data), 64'hFF02FE03);
    drain();

    // saturation, shift 2
    for (int i = 0; i < VW; i++) e[i] = 0;
    e[0] = 1000;
    e[1] = -1000;
    send(e, 2);
    check("t3_data0", 64'(out_data), 64'h0000807F);
    check("t3_sat", 64'(out_sat), 64'd1);
    drain();
    check("t3_total", 64'(sat_total), 64'd2);

    // backpressure
    for (int i = 0; i < VW; i++) e[i] = 3 * i - 40;
    bp_cnt = 0;
    bp_en  = 1'b1;
    send(e, 1);
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      if (out_valid && !out_ready) check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    bp_en     = 1'b0;
    out_ready = 1'b1;
    drain();

    // back-to-back
    for (int i = 0; i < VW; i++) begin
      e[i]  = 2 * i;
      eb[i] = -i;
    end
    send(e, 0);
    t0 = cyc;
    t1 = 0;
    nv = 0;
    fork
      begin
        send(eb, 0);
        t1 = cyc;
      end
      begin
        repeat (16) begin
          @(negedge clk);
          if (out_valid) nv++;
        end
      end
    join
    check("b2b_accept_gap", 64'(t1 - t0), 64'd8);
    check("b2b_valid_run", 64'(nv), 64'd16);
    drain();

    // reset during beat 3
    for (int i = 0; i < VW; i++) e[i] = 1000;
    send(e, 0);
    n = 0;
    while (!(out_valid && out_beat == 3'd3) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_beat3", 64'(out_beat), 64'd3);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_total", 64'(sat_total), 64'd0);
    check("mid_rst_beat", 64'(out_beat), 64'd0);
    for (int i = 0; i < VW; i++) e[i] = i - 16;
    send(e, 0);
    check("post_rst_beat0", 64'(out_beat), 64'd0);
    check("post_rst_data0", 64'(out_data), 64'hF3F2F1F0);
    drain();
    check("post_rst_total", 64'(sat_total), 64'd0);

    // drive sat_total to 0xFFFE: 2047*32 + 30
    for (int i = 0; i < VW; i++) begin
      e[i]  = 1000;
      eb[i] = (i < 30) ? 1000 : 0;
    end
    for (int k = 0; k < 2047; k++) send(e, 0);
    send(eb, 0);
    send(e, 0);
    check("total_fffe", 64'(sat_total), 64'hFFFE);
    @(posedge clk);
    #1;
    check("total_sticky", 64'(sat_total), 64'hFFFF);
    stats_clear = 1'b1;
    @(posedge clk);
    #1;
    stats_clear = 1'b0;
    check("clear_wins", 64'(sat_total), 64'd0);
    @(posedge clk);
    #1;
    check("after_clear", 64'(sat_total), 64'd4);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/act_requant_packer.md
# act_requant_packer

Downstream stage of the PE core activation unit. It captures one activated vector of `VECTOR_WIDTH` signed `DATA_WIDTH` elements per handshake. Each element is requantized to signed `OUT_WIDTH` by a rounding arithmetic right shift with saturation. The result streams out as `LANES` elements per beat over a valid/ready interface toward the output buffer / writeback path.

## Interface
- `DATA_WIDTH`, 32: input element width, signed two's complement
- `VECTOR_WIDTH`, 32: elements per input vector; must be a multiple of `LANES`
- `OUT_WIDTH`, 8: output element width, signed
- `LANES`, 4: output elements per beat; BEATS = `VECTOR_WIDTH`/`LANES`
- `SHIFT_W`, 5: width of `shift`, equal to $clog2(`DATA_WIDTH`)
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: input vector valid
- `in_ready` out 1: block can accept a vector this cycle
- `in_data` in `VECTOR_WIDTH`*`DATA_WIDTH`: element i at [i*`DATA_WIDTH` +: `DATA_WIDTH`]
- `shift` in `SHIFT_W`: requant right-shift amount, sampled with `in_data`
- `out_valid` out 1: beat valid
- `out_ready` in 1: consumer accepts beat
- `out_data` out `LANES`*`OUT_WIDTH`: lane l = element beat*`LANES`+l, at [l*`OUT_WIDTH` +: `OUT_WIDTH`]
- `out_last` out 1: current beat is beat BEATS-1
- `out_beat` out $clog2(BEATS): index of current beat
- `out_sat` out 1: at least one lane of the current beat saturated
- `stats_clear` in 1: synchronous clear of `sat_total`
- `sat_total` out 16: saturating count of saturated elements in accepted beats

## Operation
- States: IDLE (no vector held) and STREAM (vector held, beats pending).
- `in_ready` = (state==IDLE) | (`out_valid` & `out_ready` & `out_last`). This is combinational and gives zero-bubble back-to-back vectors.
- On input accept (`in_valid` & `in_ready`):
  - latch all of `in_data` into the vector buffer and latch `shift`;
  - set beat counter to 0 and go to STREAM.
- In STREAM, `out_valid`=1 and the beat counter drives `out_beat`.
- On `out_valid` & `out_ready`:
  - if not last: beat+1;
  - if last and no simultaneous input accept: go to IDLE and set `out_valid`=0;
  - if last with simultaneous input accept: stay in STREAM with beat=0 on the new vector.
- Requant per element x (signed `DATA_WIDTH`), s=latched shift:
  - r = (x + (s>0 ? 2^(s-1) : 0)) >>> s, computed in `DATA_WIDTH`+1 bits so no overflow; round half toward +inf;
  - r > 2^(`OUT_WIDTH`-1)-1 gives 2^(`OUT_WIDTH`-1)-1, saturated;
  - r < -2^(`OUT_WIDTH`-1) gives -2^(`OUT_WIDTH`-1), saturated;
  - otherwise the low `OUT_WIDTH` bits of r.
- `out_data`, `out_sat`, `out_last` and `out_beat` are combinational from the buffer, latched shift and beat counter.
- While `out_valid` & !`out_ready`, all output fields hold stable.
- `sat_total` adds the popcount of saturated lanes on each accepted beat and sticks at 16'hFFFF.
- `stats_clear` zeroes `sat_total` and takes priority over the increment in the same cycle.
- `in_data` and `shift` are ignored when not accepted.

## Timing
- Reset (`rst`=1 at an edge), next cycle:
  - state IDLE, `out_valid`=0, beat=0, `out_beat`=0;
  - buffer and latched shift are 0, so `out_data`=0, `out_sat`=0, `out_last`=0;
  - `sat_total`=0 and `in_ready`=1.
- Reset mid-stream discards the held vector and its remaining beats with no further beats.
- Latency: input accepted at edge N gives beat 0 valid during cycle N+1 (after edge N).
- Throughput: one beat per cycle with `out_ready`=1 held. A vector completes BEATS cycles after acceptance.
- Sustained input gives 100% output occupancy.
- BEATS=1 is legal: every beat is last, and `in_ready` follows `out_ready` while streaming.

## Test plan
- shift=0, element i = i-16, `out_ready`=1:
  - 8 beats on consecutive cycles; beat 0 = {-13,-14,-15,-16} (lane3..lane0);
  - `out_last` only on beat 7; `out_sat`=0.
- shift=1, elements 5, -5, 3, -3:
  - beat 0 = lane0 3, lane1 -2, lane2 2, lane3 -1 (`out_data`=32'hFF02FE03);
  - shift=2, x=1000 gives 127 and x=-1000 gives -128, with `out_sat`=1 and `sat_total` increased by 2.
- Backpressure: `out_ready` pattern 1,0,0,1,...
  - `out_data`/`out_beat` are stable in stalled cycles;
  - `in_ready`=0 throughout; all 8 beats delivered in order.
- Back-to-back: two vectors with `in_valid` held and `out_ready`=1:
  - 16 consecutive valid beats, no gap;
  - second vector accepted in the same cycle as beat 7 of the first.
- Reset asserted for 1 cycle during beat 3:
  - following cycle `out_valid`=0, `in_ready`=1, `sat_total`=0;
  - a new vector then streams from beat 0.
- `sat_total`:
  - force 16'hFFFE, then accept a beat with 4 saturated lanes, giving 16'hFFFF;
  - `stats_clear` asserted with a saturating beat accepted in the same cycle gives 0.
